// File: rtl/conv3x3_window_mac_pkg.sv
// conv_pkg: shared constants for the 3x3 convolution stage.
//   DATA_W_DEF / ACC_W_DEF : default pixel/weight and result widths
//   KERNEL_SIZE / KERNEL_TAPS : kernel geometry
//   widx_e / tap_idx : row-major tap ordering (0 = top-left, 8 = bottom-right)
package conv_pkg;
  localparam int DATA_W_DEF  = 16;
  localparam int ACC_W_DEF   = 36;
  localparam int KERNEL_SIZE = 3;
  localparam int KERNEL_TAPS = KERNEL_SIZE * KERNEL_SIZE;

  typedef enum logic [3:0] {
    W_TL = 4'd0, W_TC = 4'd1, W_TR = 4'd2,
    W_ML = 4'd3, W_MC = 4'd4, W_MR = 4'd5,
    W_BL = 4'd6, W_BC = 4'd7, W_BR = 4'd8
  } widx_e;

  function automatic int tap_idx(input int r, input int c);
    return r * KERNEL_SIZE + c;
  endfunction
endpackage

// File: rtl/conv3x3_window_mac_if.sv
// Stream/weight bus of the 3x3 convolution stage.
//   master: producer side (drives pixels, start, weights; observes results)
//   slave : the convolution block
interface conv3x3_window_mac_if import conv_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ACC_WIDTH  = ACC_W_DEF
);
  logic                  start;
  logic                  in_valid;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  w_load;
  logic [3:0]            w_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  out_valid;
  logic [ACC_WIDTH-1:0]  out_data;
  logic                  out_last;
  logic                  busy;

  modport master (
    output start, in_valid, in_data, w_load, w_addr, w_data,
    input  out_valid, out_data, out_last, busy
  );
  modport slave (
    input  start, in_valid, in_data, w_load, w_addr, w_data,
    output out_valid, out_data, out_last, busy
  );
endinterface

// File: rtl/conv3x3_window_mac_mac9_pipe.sv
// mac9_pipe: 9 signed multipliers + registered adder tree, 2-cycle latency.
//   i_taps/i_wts : row-major window taps and weights
//   i_vld/i_last : window valid tag and end-of-frame tag
//   o_sum        : sign-extended sum, held while o_vld is low
//   o_vld/o_last : result strobe and frame-end marker
module mac9_pipe import conv_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ACC_WIDTH  = ACC_W_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0] i_taps,
  input  logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0] i_wts,
  input  logic                                   i_vld,
  input  logic                                   i_last,
  output logic [ACC_WIDTH-1:0]                   o_sum,
  output logic                                   o_vld,
  output logic                                   o_last
);
  localparam int PW     = 2 * DATA_WIDTH;
  localparam int STAGES = 2;

  logic [KERNEL_TAPS-1:0][PW-1:0] w_prod, r_prod;
  logic [STAGES:1]                r_vld_pipe, r_last_pipe;
  logic [ACC_WIDTH-1:0]           w_sum, r_sum;

  for (genvar k = 0; k < KERNEL_TAPS; k++) begin : g_mul
    assign w_prod[k] = $signed(i_taps[k]) * $signed(i_wts[k]);
  end

  always_comb begin
    w_sum = '0;
    for (int k = 0; k < KERNEL_TAPS; k++)
      w_sum = w_sum + {{(ACC_WIDTH-PW){r_prod[k][PW-1]}}, r_prod[k]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_prod      <= '0;
      r_vld_pipe  <= '0;
      r_last_pipe <= '0;
      r_sum       <= '0;
    end else begin
      r_prod      <= w_prod;
      r_vld_pipe  <= {r_vld_pipe[STAGES-1:1], i_vld};
      r_last_pipe <= {r_last_pipe[STAGES-1:1], i_vld & i_last};
      // only a real window updates the result; bubbles leave it held
      if (r_vld_pipe[1]) r_sum <= w_sum;
    end
  end

  assign o_sum  = r_sum;
  assign o_vld  = r_vld_pipe[STAGES];
  assign o_last = r_last_pipe[STAGES];
endmodule

// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: streaming 3x3 convolution, stride 1, no padding.
//   clk, rst (async, active low)
//   bus.slave: start, in_valid/in_data pixel stream, w_load/w_addr/w_data
//              weight writes, out_valid/out_data/out_last results, busy.
// Two IMG_W-deep row delays feed the right column of a 3x3 window; the
// window plus a valid tag goes into mac9_pipe. Latency pixel->result 3.
module conv3x3_window_mac import conv_pkg::*; #(
  parameter int DATA_WIDTH = DATA_W_DEF,
  parameter int ACC_WIDTH  = ACC_W_DEF,
  parameter int IMG_W      = 28,
  parameter int IMG_H      = 28
) (
  input logic                  clk,
  input logic                  rst,
  conv3x3_window_mac_if.slave  bus
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [IMG_W-1:0][DATA_WIDTH-1:0]       r_rd1, r_rd2;
  logic [KERNEL_TAPS-1:0][DATA_WIDTH-1:0] r_win, r_wts;
  logic [CW-1:0]                          r_col, w_col;
  logic [RW-1:0]                          r_row, w_row;
  logic                                   r_win_vld, r_win_last, r_busy;
  logic                                   w_acc, w_win_ok, w_last;
  logic                                   w_mac_vld, w_mac_last;
  logic [ACC_WIDTH-1:0]                   w_mac_sum;
  logic [DATA_WIDTH-1:0]                  w_rd1_out, w_rd2_out;

  assign w_acc     = bus.in_valid;
  // start with a pixel: that pixel is treated as (0,0)
  assign w_col     = bus.start ? '0 : r_col;
  assign w_row     = bus.start ? '0 : r_row;
  assign w_win_ok  = w_acc && (w_col >= CW'(2)) && (w_row >= RW'(2));
  assign w_last    = (w_col == CW'(IMG_W-1)) && (w_row == RW'(IMG_H-1));
  assign w_rd1_out = r_rd1[IMG_W-1];
  assign w_rd2_out = r_rd2[IMG_W-1];

  // row delays, window and counters; they move only on accepted pixels
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd1 <= '0;
      r_rd2 <= '0;
      r_win <= '0;
      r_col <= '0;
      r_row <= '0;
    end else if (w_acc) begin
      r_rd1 <= {r_rd1[IMG_W-2:0], bus.in_data};
      r_rd2 <= {r_rd2[IMG_W-2:0], w_rd1_out};
      for (int r = 0; r < KERNEL_SIZE; r++)
        for (int c = 0; c < KERNEL_SIZE-1; c++)
          r_win[tap_idx(r, c)] <= r_win[tap_idx(r, c+1)];
      r_win[tap_idx(0, 2)] <= w_rd2_out;
      r_win[tap_idx(1, 2)] <= w_rd1_out;
      r_win[tap_idx(2, 2)] <= bus.in_data;
      if (w_col == CW'(IMG_W-1)) begin
        r_col <= '0;
        r_row <= (w_row == RW'(IMG_H-1)) ? '0 : w_row + RW'(1);
      end else begin
        r_col <= w_col + CW'(1);
        r_row <= w_row;
      end
    end else if (bus.start) begin
      r_col <= '0;
      r_row <= '0;
    end
  end

  // window tag lives for exactly one cycle, so a start needs no extra clear
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_win_vld  <= 1'b0;
      r_win_last <= 1'b0;
    end else begin
      r_win_vld  <= w_win_ok;
      r_win_last <= w_win_ok && w_last;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wts <= '0;
    end else begin
      for (int k = 0; k < KERNEL_TAPS; k++)
        if (bus.w_load && (bus.w_addr == 4'(k))) r_wts[k] <= bus.w_data;
    end
  end

  // busy drops after out_last unless the next frame has already begun
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_busy <= 1'b0;
    else if (w_acc)
      r_busy <= 1'b1;
    else if (w_mac_last && (r_col == '0) && (r_row == '0))
      r_busy <= 1'b0;
  end

  mac9_pipe #(.DATA_WIDTH(DATA_WIDTH), .ACC_WIDTH(ACC_WIDTH)) u_mac (
    .clk    (clk),
    .rst    (rst),
    .i_taps (r_win),
    .i_wts  (r_wts),
    .i_vld  (r_win_vld),
    .i_last (r_win_last),
    .o_sum  (w_mac_sum),
    .o_vld  (w_mac_vld),
    .o_last (w_mac_last)
  );

  assign bus.out_valid = w_mac_vld;
  assign bus.out_data  = w_mac_sum;
  assign bus.out_last  = w_mac_last;
  assign bus.busy      = r_busy;
endmodule

// File: tb/tb_conv3x3_window_mac.sv
module tb_conv3x3_window_mac;
  localparam int DW = 16;
  localparam int AW = 36;
  localparam int W  = 4;
  localparam int H  = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  conv3x3_window_mac_if #(.DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus();
  conv3x3_window_mac #(.DATA_WIDTH(DW), .ACC_WIDTH(AW), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input longint got, input longint exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", nm, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct { longint sum; bit last; int due; } exp_t;
  exp_t   eq[$];
  longint m_w[9];
  longint img[H][W];
  longint ptap[9];
  bit     pend, plast, m_busy;
  int     m_r, m_c;
  int     ecnt = 0;
  int     last_vis_edge = -10;

  initial forever begin
    @(posedge clk);
    ecnt++;
    if (!rst) begin
      eq.delete();
      foreach (m_w[k]) m_w[k] = 0;
      m_r = 0; m_c = 0; pend = 0; m_busy = 0;
    end else begin
      // product stage for the window formed last edge uses weights before this edge's write
      if (pend) begin
        exp_t e;
        e.sum = 0;
        for (int k = 0; k < 9; k++) e.sum += ptap[k] * m_w[k];
        e.last = plast;
        e.due  = ecnt + 1;
        eq.push_back(e);
        pend = 0;
      end
      if (bus.in_valid) m_busy = 1;
      else if (last_vis_edge == ecnt - 1 && m_r == 0 && m_c == 0) m_busy = 0;
      if (bus.start) begin m_r = 0; m_c = 0; end
      if (bus.in_valid) begin
        img[m_r][m_c] = longint'($signed(bus.in_data));
        if (m_r >= 2 && m_c >= 2) begin
          for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++)
              ptap[i*3+j] = img[m_r-2+i][m_c-2+j];
          plast = (m_r == H-1) && (m_c == W-1);
          pend  = 1;
        end
        m_c++;
        if (m_c == W) begin
          m_c = 0;
          m_r = (m_r == H-1) ? 0 : m_r + 1;
        end
      end
      if (bus.w_load && bus.w_addr < 9) m_w[bus.w_addr] = longint'($signed(bus.w_data));
    end
  end

  // ---------------- compare process ----------------
  longint hold = 0;
  longint obs_d[$];
  bit     obs_l[$];
  int     obs_e[$];

  initial forever begin
    @(negedge clk);
    if (!rst) begin
      hold = 0;
      chk("rst out_valid", bus.out_valid, 0);
      chk("rst out_data", $signed(bus.out_data), 0);
      chk("rst busy", bus.busy, 0);
    end else begin
      if (bus.out_valid) begin
        obs_d.push_back($signed(bus.out_data));
        obs_l.push_back(bus.out_last);
        obs_e.push_back(ecnt);
      end
      if (eq.size() > 0 && eq[0].due == ecnt) begin
        exp_t e;
        e = eq.pop_front();
        chk("out_valid", bus.out_valid, 1);
        chk("out_data", $signed(bus.out_data), e.sum);
        chk("out_last", bus.out_last, longint'(e.last));
        hold = e.sum;
        if (e.last) last_vis_edge = ecnt;
      end else begin
        chk("idle out_valid", bus.out_valid, 0);
        chk("idle out_last", bus.out_last, 0);
        chk("held out_data", $signed(bus.out_data), hold);
      end
      chk("busy", bus.busy, longint'(m_busy));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask
  task automatic idle(input int n);
    repeat (n) step();
  endtask
  task automatic px(input longint d);
    bus.in_valid = 1'b1;
    bus.in_data  = DW'(d);
    step();
    bus.in_valid = 1'b0;
  endtask
  task automatic wset(input int a, input longint v);
    bus.w_load = 1'b1;
    bus.w_addr = 4'(a);
    bus.w_data = DW'(v);
    step();
    bus.w_load = 1'b0;
  endtask
  task automatic ones();
    for (int a = 0; a < 9; a++) wset(a, 1);
  endtask
  task automatic clr_obs();
    obs_d.delete(); obs_l.delete(); obs_e.delete();
  endtask
  task automatic frame(input bit bub);
    for (int p = 1; p <= 16; p++) begin
      px(p);
      if (bub) idle(1);
    end
  endtask
  task automatic chk_basic(input string nm, input int base);
    longint ref_v[4];
    ref_v = '{54, 63, 90, 99};
    for (int k = 0; k < 4; k++) begin
      if (obs_d.size() > base + k) begin
        chk({nm, " value"}, obs_d[base+k], ref_v[k]);
        chk({nm, " last"}, obs_l[base+k], (k == 3) ? 1 : 0);
      end
    end
  endtask

  initial begin
    int px11;
    bus.start = 0; bus.in_valid = 0; bus.in_data = '0;
    bus.w_load = 0; bus.w_addr = '0; bus.w_data = '0;
    #1 rst = 1'b0;
    idle(3);
    rst = 1'b1;
    step();

    // basic 4x4, all ones
    ones();
    clr_obs();
    px11 = 0;
    for (int p = 1; p <= 16; p++) begin
      px(p);
      if (p == 11) px11 = ecnt;
    end
    idle(6);
    chk("basic count", obs_d.size(), 4);
    chk_basic("basic", 0);
    if (obs_e.size() > 0) chk("basic latency edges", obs_e[0] - px11, 2);
    chk("busy after frame", bus.busy, 0);

    // bubbles
    clr_obs();
    frame(1);
    idle(6);
    chk("bubble count", obs_d.size(), 4);
    chk_basic("bubble", 0);

    // signed path, centre weight only; addr 9 write must be ignored
    for (int a = 0; a < 9; a++) wset(a, (a == 4) ? -2 : 0);
    wset(9, 7);
    clr_obs();
    for (int p = 1; p <= 16; p++) px((p == 6) ? -32768 : p);
    idle(6);
    chk("signed count", obs_d.size(), 4);
    if (obs_d.size() > 1) begin
      chk("signed first", obs_d[0], 65536);
      chk("signed second", obs_d[1], -14);
    end

    // restart after a partial frame
    ones();
    clr_obs();
    for (int p = 1; p <= 9; p++) px(p);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    frame(0);
    idle(6);
    chk("restart count", obs_d.size(), 4);
    chk_basic("restart", 0);

    // back-to-back frames
    clr_obs();
    frame(0);
    for (int p = 1; p <= 16; p++) begin
      px(p);
      if (p == 3) chk("busy across frames", bus.busy, 1);
    end
    idle(6);
    chk("b2b count", obs_d.size(), 8);
    chk_basic("b2b f1", 0);
    chk_basic("b2b f2", 4);

    // random traffic incl. weight writes, bubbles and starts
    for (int a = 0; a < 9; a++) wset(a, $signed(16'($urandom())));
    for (int n = 0; n < 800; n++) begin
      bus.in_valid = ($urandom_range(3) != 0);
      bus.in_data  = 16'($urandom());
      bus.start    = ($urandom_range(96) == 0);
      bus.w_load   = ($urandom_range(12) == 0);
      bus.w_addr   = 4'($urandom_range(11));
      bus.w_data   = 16'($urandom());
      step();
    end
    bus.in_valid = 0; bus.start = 0; bus.w_load = 0;
    idle(6);

    // async reset mid-stream
    ones();
    for (int p = 1; p <= 12; p++) px(p * 100);
    #1 rst = 1'b0;
    #1;
    chk("async rst out_valid", bus.out_valid, 0);
    chk("async rst out_data", $signed(bus.out_data), 0);
    chk("async rst busy", bus.busy, 0);
    idle(2);
    rst = 1'b1;
    clr_obs();
    idle(3);
    chk("post-reset quiet", obs_d.size(), 0);
    ones();
    clr_obs();
    frame(0);
    idle(6);
    chk("post-reset count", obs_d.size(), 4);
    chk_basic("post-reset", 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
